// File: rtl/mram_serial_host_if.sv
// Request/response and serial-link signals of the MRAM serial host.
// The master modport is the host block itself; slave is the environment
// (host logic on the request side, MRAM top on the serial side).
interface mram_serial_host_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_word_sel;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ser_addr;
    logic              ser_data;
    logic [2:0]        rw_sel;
    logic              ser_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        input  req_valid, req_write, req_word_sel, req_addr, req_wdata, ser_rdata,
        output req_ready, ser_addr, ser_data, rw_sel, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        output req_valid, req_write, req_word_sel, req_addr, req_wdata, ser_rdata,
        input  req_ready, ser_addr, ser_data, rw_sel, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/mram_serial_host.sv
// Host-side serial master for the MRAM serial access block.
// Takes one parallel read/write request, shifts address and write data out
// MSB first, presents the command code for a fixed window and, for reads,
// collects the serial read-back into a parallel response. Every output is
// driven straight from a flop.
module mram_serial_host #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int CMD_CYCLES = 4,
    parameter int RD_LAT     = 2   // must be >= 2: WAIT lasts RD_LAT-1 cycles
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    mram_serial_host_if.master  bus
);

    localparam int CNT_W = $clog2(ADDR_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Word select 00 is an alias for a full-word access.
    function automatic logic [1:0] remap_word_sel(input logic [1:0] sel);
        remap_word_sel = (sel == 2'b00) ? 2'b01 : sel;
    endfunction

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [ADDR_W-1:0] addr_sr_q,   addr_sr_d;
    logic [DATA_W-1:0] data_sr_q,   data_sr_d;
    logic [DATA_W-2:0] cap_q,       cap_d;
    logic              write_q,     write_d;
    logic [1:0]        sel_q,       sel_d;
    logic              ser_addr_q,  ser_addr_d;
    logic              ser_data_q,  ser_data_d;
    logic [2:0]        rw_sel_q,    rw_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              busy_q,      busy_d;
    logic              req_ready_q, req_ready_d;

    logic [CNT_W-1:0]  cap_last_s;

    // Index of the last capture sample: full word or a single byte.
    always_comb begin
        if (sel_q == 2'b01) begin
            cap_last_s = CNT_W'(DATA_W - 1);
        end else begin
            cap_last_s = CNT_W'(DATA_W / 2 - 1);
        end
    end

    // Next-state and next-output logic; serial outputs default to idle-low.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        addr_sr_d   = addr_sr_q;
        data_sr_d   = data_sr_q;
        cap_d       = cap_q;
        write_d     = write_q;
        sel_d       = sel_q;
        ser_addr_d  = 1'b0;
        ser_data_d  = 1'b0;
        rw_sel_d    = 3'b000;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    // The first address/data bit goes out already on the accept edge.
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    write_d    = bus.req_write;
                    sel_d      = remap_word_sel(bus.req_word_sel);
                    cap_d      = '0;
                    ser_addr_d = bus.req_addr[ADDR_W-1];
                    addr_sr_d  = {bus.req_addr[ADDR_W-2:0], 1'b0};
                    if (bus.req_write) begin
                        ser_data_d = bus.req_wdata[DATA_W-1];
                        data_sr_d  = {bus.req_wdata[DATA_W-2:0], 1'b0};
                    end else begin
                        ser_data_d = 1'b0;
                        data_sr_d  = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                    state_d   = ST_ACCESS;
                    bit_cnt_d = '0;
                    rw_sel_d  = {write_q, sel_q};
                end else begin
                    // data_sr drains to zero, so ser_data idles low after the word.
                    ser_addr_d = addr_sr_q[ADDR_W-1];
                    addr_sr_d  = {addr_sr_q[ADDR_W-2:0], 1'b0};
                    ser_data_d = data_sr_q[DATA_W-1];
                    data_sr_d  = {data_sr_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                if (bit_cnt_q == CNT_W'(CMD_CYCLES - 1)) begin
                    bit_cnt_d = '0;
                    if (write_q) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    rw_sel_d  = {write_q, sel_q};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (bit_cnt_q == CNT_W'(RD_LAT - 2)) begin
                    state_d   = ST_CAPTURE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                // cap starts cleared, so byte reads come out zero-extended.
                cap_d = {cap_q[DATA_W-3:0], bus.ser_rdata};
                if (bit_cnt_q == cap_last_s) begin
                    state_d     = ST_DONE;
                    bit_cnt_d   = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = {cap_q, bus.ser_rdata};
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and output registers; reset aborts any transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            addr_sr_q   <= '0;
            data_sr_q   <= '0;
            cap_q       <= '0;
            write_q     <= 1'b0;
            sel_q       <= 2'b01;
            ser_addr_q  <= 1'b0;
            ser_data_q  <= 1'b0;
            rw_sel_q    <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_sr_q   <= addr_sr_d;
            data_sr_q   <= data_sr_d;
            cap_q       <= cap_d;
            write_q     <= write_d;
            sel_q       <= sel_d;
            ser_addr_q  <= ser_addr_d;
            ser_data_q  <= ser_data_d;
            rw_sel_q    <= rw_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.ser_addr  = ser_addr_q;
    assign bus.ser_data  = ser_data_q;
    assign bus.rw_sel    = rw_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = busy_q;

endmodule
